// File: rtl/adder64b_seq_ctrl_if.sv
// rtl/adder64b_seq_ctrl_if.sv - request/result handshake bundle for the sequential adder
interface adder64b_seq_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_o;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, c_o, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, c_o, ovf, zero
  );
endinterface

// File: rtl/adder64b_seq_ctrl.sv
// rtl/adder64b_seq_ctrl.sv - multi-cycle add/subtract reusing one SLICE-bit adder slice
module adder64b_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input logic                clk,
  input logic                reset,
  adder64b_seq_ctrl_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             c_o;
  logic             ovf;
  logic             zero;

  logic [SLICE-1:0] ca;
  logic [SLICE-1:0] cb;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE-1:0] s;
  logic [SLICE:0]   c;
  logic [WIDTH-1:0] result_next;

  // One slice of partial full adder cells, steered onto chunk k
  always_comb begin
    ca   = op_a[int'(k)*SLICE +: SLICE];
    cb   = op_b[int'(k)*SLICE +: SLICE];
    p    = ca | cb;
    g    = ca & cb;
    c    = '0;
    s    = '0;
    c[0] = carry;
    for (int i = 0; i < SLICE; i++) begin
      s[i]   = ca[i] ^ cb[i] ^ c[i];
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    result_next = result;
    result_next[int'(k)*SLICE +: SLICE] = s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      k      <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      c_o    <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a  <= bus.a;
            op_b  <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.sub;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result <= result_next;
          carry  <= c[SLICE];
          if (k == K_LAST) begin
            // Flags are published only once the whole word is known
            c_o   <= c[SLICE];
            ovf   <= c[SLICE-1] ^ c[SLICE];
            zero  <= (result_next == '0);
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result;
  assign bus.c_o       = c_o;
  assign bus.ovf       = ovf;
  assign bus.zero      = zero;
endmodule

// File: tb/tb_adder64b_seq_ctrl.sv
// tb/tb_adder64b_seq_ctrl.sv - directed self-checking bench for adder64b_seq_ctrl
module tb_adder64b_seq_ctrl;
  localparam int WIDTH = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adder64b_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();
  adder64b_seq_ctrl #(.WIDTH(WIDTH), .SLICE(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the edge where out_valid is first seen
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!bus.out_valid && cycles < 20);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic [63:0] exp_res, input logic exp_c,
                        input logic exp_ovf, input logic exp_zero);
    int cyc;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = ~b;
    bus.sub      = ~sub;
    wait_done(cyc);
    check({tag, " latency"}, 64'(cyc), 64'd4);
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " c_o"}, 64'(bus.c_o), 64'(exp_c));
    check({tag, " ovf"}, 64'(bus.ovf), 64'(exp_ovf));
    check({tag, " zero"}, 64'(bus.zero), 64'(exp_zero));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, " out_valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, " in_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int cyc;
    int seen;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst result", bus.result, 64'd0);
    check("rst c_o", 64'(bus.c_o), 64'd0);
    check("rst ovf", 64'(bus.ovf), 64'd0);
    check("rst zero", 64'(bus.zero), 64'd0);

    run_op("add_1_1", 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
    run_op("add_chunk_carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_5_7", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_7_5", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);

    // Back-pressure in DONE with a stray request that must be ignored
    bus.a        = 64'h0123_4567_89AB_CDEF;
    bus.b        = 64'h1111_1111_1111_1111;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_done(cyc);
    check("hold latency", 64'(cyc), 64'd4);
    for (int i = 0; i < 3; i++) begin
      check("hold result", bus.result, 64'h1234_5678_9ABC_DF00);
      check("hold c_o", 64'(bus.c_o), 64'd0);
      check("hold out_valid", 64'(bus.out_valid), 64'd1);
      check("hold in_ready", 64'(bus.in_ready), 64'd0);
      if (i == 1) begin
        bus.a        = 64'd0;
        bus.b        = 64'd0;
        bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
    check("hold result_end", bus.result, 64'h1234_5678_9ABC_DF00);
    check("hold zero_end", 64'(bus.zero), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("hold in_ready_back", 64'(bus.in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("hold no_stray_op", 64'(bus.in_ready), 64'd1);

    // Reset landing on the second RUN cycle
    bus.a        = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.b        = 64'h0000_0000_0000_0001;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.out_ready = 1'b0;
    check("midrst in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst result", bus.result, 64'd0);
    check("midrst c_o", 64'(bus.c_o), 64'd0);
    check("midrst zero", 64'(bus.zero), 64'd0);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("midrst no_out_valid", 64'(seen), 64'd0);
    run_op("after_rst", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
